// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file (r0 = 0) with write-through bypass and per-register busy scoreboard.
// Latency: reads are combinational (0 cycles); writes, allocs and flushes take effect on the next rising edge.
// Backpressure: none; every input is sampled every cycle, no handshake.
//
// Ports:
//   clk, rst                       clock and asynchronous active-high reset
//   rd_addr / rd_data / rd_busy    NREAD packed read ports (port i at slice i)
//   wr_en / wr_addr / wr_data      NWRITE packed write-back ports, higher index wins on collision
//   alloc_en / alloc_addr          mark a register busy when an instruction producing it issues
//   flush                          clear every busy bit
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 4,
    parameter int NWRITE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREAD*ADDR_W-1:0]  rd_addr,
    output logic [NREAD*DATA_W-1:0]  rd_data,
    output logic [NREAD-1:0]         rd_busy,
    input  logic [NWRITE-1:0]        wr_en,
    input  logic [NWRITE*ADDR_W-1:0] wr_addr,
    input  logic [NWRITE*DATA_W-1:0] wr_data,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic                     flush
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        if (NREAD < 1 || NREAD > 8) begin : g_bad_nread
            $error("regfile_mp: NREAD must be in 1..8");
        end
        if (NWRITE < 1 || NWRITE > 4) begin : g_bad_nwrite
            $error("regfile_mp: NWRITE must be in 1..4");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    // Unpacked view of the write ports; wv excludes writes to r0 so that
    // storage, bypass and scoreboard all ignore them uniformly.
    logic [ADDR_W-1:0] wa [NWRITE];
    logic [DATA_W-1:0] wd [NWRITE];
    logic [NWRITE-1:0] wv;

    genvar gj;
    generate
        for (gj = 0; gj < NWRITE; gj++) begin : g_wport
            assign wa[gj] = wr_addr[gj*ADDR_W +: ADDR_W];
            assign wd[gj] = wr_data[gj*DATA_W +: DATA_W];
            assign wv[gj] = wr_en[gj] && (wa[gj] != '0);
        end
    endgenerate

    // Storage: ascending port loop so the highest-index port's assignment
    // is the one that lands on a collision. mem[0] is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wv[j]) begin
                    mem[wa[j]] <= wd[j];
                end
            end
        end
    end

    // Scoreboard next state: completions clear first, then an alloc sets,
    // so a same-cycle alloc+write leaves the register busy (newer producer).
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wv[j]) begin
                    busy_nxt[wa[j]] = 1'b0;
                end
            end
            if (alloc_en && alloc_addr != '0) begin
                busy_nxt[alloc_addr] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Read ports: bypass from the highest-index matching write, otherwise
    // storage. A matching write also releases the hazard this cycle.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] d;
        logic              hit;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra  = rd_addr[i*ADDR_W +: ADDR_W];
            d   = mem[ra];
            hit = 1'b0;
            for (int j = 0; j < NWRITE; j++) begin
                if (wv[j] && wa[j] == ra) begin
                    hit = 1'b1;
                    d   = wd[j];
                end
            end
            if (rst || ra == '0) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
                rd_busy[i]                  = 1'b0;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = d;
                rd_busy[i]                  = busy[ra] & ~hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (directed scenarios plus a random soak against a reference model).
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Expectations are queued when stimulus is applied and popped when the cycle's outputs are sampled.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int NW    = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic              flush;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .NWRITE(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .alloc_en  (alloc_en),
        .alloc_addr(alloc_addr),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    // Reference state, updated after each rising edge from the applied inputs.
    logic [31:0] m_mem  [DEPTH];
    logic        m_busy [DEPTH];

    task automatic idle();
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        flush      = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic push_exp(input int p, input logic [31:0] d, input logic b);
        exp_t e;
        e.port = p;
        e.data = d;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    // Model expectation for every read port given the currently applied inputs.
    task automatic push_model();
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic          hit;
        for (int p = 0; p < NR; p++) begin
            a = rd_addr[p*AW +: AW];
            if (rst || a == 0) begin
                push_exp(p, 32'h0, 1'b0);
            end else begin
                d   = m_mem[a];
                hit = 1'b0;
                for (int j = NW - 1; j >= 0; j--) begin
                    if (!hit && wr_en[j] && wr_addr[j*AW +: AW] == a) begin
                        d   = wr_data[j*DW +: DW];
                        hit = 1'b1;
                    end
                end
                push_exp(p, d, m_busy[a] && !hit);
            end
        end
    endtask

    task automatic model_commit();
        logic [AW-1:0] a;
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_mem[k]  = 32'h0;
                m_busy[k] = 1'b0;
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                a = wr_addr[j*AW +: AW];
                if (wr_en[j] && a != 0) m_mem[a] = wr_data[j*DW +: DW];
            end
            if (flush) begin
                for (int k = 0; k < DEPTH; k++) m_busy[k] = 1'b0;
            end else begin
                for (int j = 0; j < NW; j++) begin
                    a = wr_addr[j*AW +: AW];
                    if (wr_en[j] && a != 0) m_busy[a] = 1'b0;
                end
                if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
            end
        end
    endtask

    // Sample outputs on the falling edge, compare every queued expectation,
    // then let the rising edge commit and advance the model.
    task automatic run_cycle(input string tag);
        exp_t        e;
        logic [31:0] got_d;
        logic        got_b;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e     = exp_q.pop_front();
            got_d = rd_data[e.port*DW +: DW];
            got_b = rd_busy[e.port];
            checks++;
            if (got_d !== e.data) begin
                errors++;
                $display("FAIL %s rd_data port%0d addr=%0d: got %h expected %h at %0t",
                         tag, e.port, rd_addr[e.port*AW +: AW], got_d, e.data, $time);
            end
            checks++;
            if (got_b !== e.busy) begin
                errors++;
                $display("FAIL %s rd_busy port%0d addr=%0d: got %b expected %b at %0t",
                         tag, e.port, rd_addr[e.port*AW +: AW], got_b, e.busy, $time);
            end
        end
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        // Reset held with write/alloc activity: outputs must stay zero.
        rst = 1'b1;
        idle();
        set_wr(0, 5'd1, 32'hCAFEF00D);
        alloc_en   = 1'b1;
        alloc_addr = 5'd1;
        for (int p = 0; p < NR; p++) begin
            set_rd(p, 5'd1);
            push_exp(p, 32'h0, 1'b0);
        end
        run_cycle("reset_held");
        rst = 1'b0;
        idle();
        for (int c = 0; c < DEPTH / NR; c++) begin
            for (int p = 0; p < NR; p++) begin
                set_rd(p, AW'(c * NR + p));
                push_exp(p, 32'h0, 1'b0);
            end
            run_cycle("reset_all_zero");
        end
    endtask

    task automatic test_reset_mid_burst();
        idle();
        set_wr(0, 5'd9,  32'h12345678);
        set_wr(1, 5'd10, 32'h9ABCDEF0);
        set_rd(0, 5'd9);  push_exp(0, 32'h12345678, 1'b0);
        set_rd(1, 5'd10); push_exp(1, 32'h9ABCDEF0, 1'b0);
        run_cycle("burst_bypass");
        rst = 1'b1;
        set_wr(0, 5'd11, 32'h55555555);
        set_wr(1, 5'd12, 32'h66666666);
        set_rd(0, 5'd11); push_exp(0, 32'h0, 1'b0);
        set_rd(1, 5'd9);  push_exp(1, 32'h0, 1'b0);
        run_cycle("burst_in_reset");
        rst = 1'b0;
        idle();
        for (int p = 0; p < NR; p++) begin
            set_rd(p, AW'(9 + p));
            push_exp(p, 32'h0, 1'b0);
        end
        run_cycle("burst_after_reset");
    endtask

    task automatic test_bypass();
        idle();
        set_wr(0, 5'd5, 32'hDEADBEEF);
        set_rd(0, 5'd0); push_exp(0, 32'h0, 1'b0);
        set_rd(2, 5'd5); push_exp(2, 32'hDEADBEEF, 1'b0);
        run_cycle("bypass_same_cycle");
        idle();
        set_rd(2, 5'd5); push_exp(2, 32'hDEADBEEF, 1'b0);
        run_cycle("bypass_stored");
    endtask

    task automatic test_collision();
        idle();
        set_wr(0, 5'd7, 32'h11111111);
        set_wr(1, 5'd7, 32'h22222222);
        set_rd(0, 5'd7); push_exp(0, 32'h22222222, 1'b0);
        run_cycle("collision_bypass");
        idle();
        set_rd(0, 5'd7); push_exp(0, 32'h22222222, 1'b0);
        set_rd(3, 5'd7); push_exp(3, 32'h22222222, 1'b0);
        run_cycle("collision_stored");
    endtask

    task automatic test_r0();
        idle();
        set_wr(1, 5'd0, 32'hFFFFFFFF);
        alloc_en   = 1'b1;
        alloc_addr = 5'd0;
        for (int p = 0; p < NR; p++) begin
            set_rd(p, 5'd0);
            push_exp(p, 32'h0, 1'b0);
        end
        run_cycle("r0_write_alloc");
        idle();
        for (int p = 0; p < NR; p++) push_exp(p, 32'h0, 1'b0);
        run_cycle("r0_after");
    endtask

    task automatic test_scoreboard();
        idle();
        alloc_en   = 1'b1;
        alloc_addr = 5'd3;
        set_rd(0, 5'd3); push_exp(0, 32'h0, 1'b0);
        run_cycle("sb_alloc_same_cycle");
        idle();
        set_rd(0, 5'd3); push_exp(0, 32'h0, 1'b1);
        run_cycle("sb_busy_after_alloc");
        set_wr(0, 5'd3, 32'h000000A5);
        set_rd(0, 5'd3); push_exp(0, 32'h000000A5, 1'b0);
        run_cycle("sb_write_releases");
        idle();
        set_rd(0, 5'd3); push_exp(0, 32'h000000A5, 1'b0);
        run_cycle("sb_cleared");
        set_wr(1, 5'd3, 32'h000000B6);
        alloc_en   = 1'b1;
        alloc_addr = 5'd3;
        set_rd(1, 5'd3); push_exp(1, 32'h000000B6, 1'b0);
        run_cycle("sb_alloc_and_write");
        idle();
        set_rd(1, 5'd3); push_exp(1, 32'h000000B6, 1'b1);
        run_cycle("sb_alloc_wins");
        flush      = 1'b1;
        alloc_en   = 1'b1;
        alloc_addr = 5'd4;
        set_rd(1, 5'd3); push_exp(1, 32'h000000B6, 1'b1);
        run_cycle("sb_flush_cycle");
        idle();
        set_rd(1, 5'd3); push_exp(1, 32'h000000B6, 1'b0);
        set_rd(2, 5'd4); push_exp(2, 32'h0, 1'b0);
        run_cycle("sb_after_flush");
    endtask

    task automatic test_soak();
        logic [AW-1:0] a;
        rst = 1'b1;
        idle();
        push_model();
        run_cycle("soak");
        rst = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < NR; p++) begin
                a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                                : AW'($urandom_range(0, 7));
                set_rd(p, a);
            end
            for (int j = 0; j < NW; j++) begin
                wr_en[j]            = ($urandom_range(0, 2) != 0);
                wr_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
                wr_data[j*DW +: DW] = $urandom();
            end
            alloc_en   = ($urandom_range(0, 1) == 1);
            alloc_addr = AW'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 31) == 0);
            push_model();
            run_cycle("soak");
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst     = 1'b1;
        rd_addr = '0;
        idle();
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]  = 32'h0;
            m_busy[k] = 1'b0;
        end
        test_reset();
        test_reset_mid_burst();
        test_bypass();
        test_collision();
        test_r0();
        test_scoreboard();
        test_soak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
